// File: rtl/csh_sweep.sv
// csh_sweep: walks every cache directory entry applying validate/unload/invalidate actions.
module csh_sweep #(
  parameter int LINE_BITS = 7,
  parameter int WAY_BITS  = 2
) (
  input  logic                          clk,
  input  logic                          RESET,
  input  logic                          START,
  input  logic [1:0]                    FUNC,
  output logic                          SWEEP_BUSY,
  output logic                          SWEEP_DONE,
  output logic                          SWEEP_ERR,
  output logic                          DIR_RD,
  output logic [LINE_BITS+WAY_BITS-1:0] ADR,
  input  logic                          DIR_VALID,
  input  logic                          DIR_DIRTY,
  output logic                          DIR_WR,
  output logic                          WR_VALID,
  output logic                          WR_DIRTY,
  output logic                          WB_REQ,
  input  logic                          WB_ACK,
  input  logic                          WB_ERR
);
  localparam int AW = LINE_BITS + WAY_BITS;
  typedef enum logic [2:0] {IDLE, READ, DECIDE, WB, WRITE} state_t;
  state_t state, state_n;
  logic [1:0] func;
  logic [AW-1:0] adr;
  logic wv, wv_n, done, err, adv, last, need_wb, need_wr;
  assign last = &adr;
  assign need_wb = func[0] & DIR_VALID & DIR_DIRTY;
  assign need_wr = (func == 2'd0) | (func[1] & DIR_VALID);
  always_comb begin
    state_n = state;
    wv_n = wv;
    adv = 1'b0;
    case (state)
      IDLE:    state_n = START ? READ : IDLE;
      READ:    state_n = DECIDE;
      DECIDE: begin
        wv_n = ~func[1];
        adv = ~need_wb & ~need_wr;
        state_n = need_wb ? WB : need_wr ? WRITE : last ? IDLE : READ;
      end
      WB:      state_n = WB_ACK ? WRITE : WB;
      WRITE: begin
        adv = 1'b1;
        state_n = last ? IDLE : READ;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (RESET) begin
      state <= IDLE;
      func <= 2'd0;
      adr <= '0;
      wv <= 1'b0;
      err <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      wv <= wv_n;
      done <= adv & last;
      if (state == IDLE && START) begin
        func <= FUNC;
        err <= 1'b0;
        adr <= '0;
      end else begin
        if (adv) adr <= adr + 1'b1;
        if (state == WB && WB_ACK && WB_ERR) err <= 1'b1;
      end
    end
  end
  assign SWEEP_BUSY = state != IDLE;
  assign SWEEP_DONE = done;
  assign SWEEP_ERR  = err;
  assign DIR_RD     = state == READ;
  assign DIR_WR     = state == WRITE;
  assign WR_VALID   = (state == WRITE) & wv;
  assign WR_DIRTY   = 1'b0;
  assign WB_REQ     = state == WB;
  assign ADR        = adr;
endmodule

// File: tb/tb_csh_sweep.sv
// tb_csh_sweep: directed scenarios against a behavioural directory and MBOX responder.
module tb_csh_sweep;
  logic clk = 1'b0;
  logic RESET, START, DIR_VALID, DIR_DIRTY, WB_ACK, WB_ERR;
  logic [1:0] FUNC;
  logic SWEEP_BUSY, SWEEP_DONE, SWEEP_ERR, DIR_RD, DIR_WR, WR_VALID, WR_DIRTY, WB_REQ;
  logic [8:0] ADR;
  logic [511:0] v_mem, d_mem;
  int ack_dly, err_adr, wb_age;
  logic stray;
  int checks = 0, failures = 0;
  int busy, dn, wrn, wbn, excl, done_adr, first_adr, bad;
  int wr_adr[600];
  logic wr_v[600], wr_d[600];
  int wb_adr[8];
  logic done_busy, done_err, first_busy, first_rd, first_err, found;

  csh_sweep dut (
    .clk(clk), .RESET(RESET), .START(START), .FUNC(FUNC),
    .SWEEP_BUSY(SWEEP_BUSY), .SWEEP_DONE(SWEEP_DONE), .SWEEP_ERR(SWEEP_ERR),
    .DIR_RD(DIR_RD), .ADR(ADR), .DIR_VALID(DIR_VALID), .DIR_DIRTY(DIR_DIRTY),
    .DIR_WR(DIR_WR), .WR_VALID(WR_VALID), .WR_DIRTY(WR_DIRTY),
    .WB_REQ(WB_REQ), .WB_ACK(WB_ACK), .WB_ERR(WB_ERR)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (DIR_RD) begin
      DIR_VALID <= v_mem[ADR];
      DIR_DIRTY <= d_mem[ADR];
    end
    wb_age <= WB_REQ ? wb_age + 1 : 0;
  end
  assign WB_ACK = (WB_REQ && wb_age == ack_dly) || stray;
  assign WB_ERR = WB_ACK && (int'(ADR) == err_adr || stray);

  task automatic run_sweep(input logic [1:0] f, input int inj_c, input logic [1:0] inj_f);
    logic prev_req = 1'b0;
    busy = 0; dn = 0; wrn = 0; wbn = 0; excl = 0; done_adr = -1; done_busy = 1'b1; done_err = 1'b0;
    @(negedge clk);
    START = 1'b1; FUNC = f;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      START = 1'b0; FUNC = 2'd0;
      if (c == 0) begin
        first_busy = SWEEP_BUSY; first_rd = DIR_RD; first_err = SWEEP_ERR; first_adr = int'(ADR);
      end
      if (SWEEP_BUSY) busy++;
      if (int'(DIR_RD) + int'(DIR_WR) + int'(WB_REQ) > 1) excl++;
      if (DIR_WR && wrn < 600) begin
        wr_adr[wrn] = int'(ADR); wr_v[wrn] = WR_VALID; wr_d[wrn] = WR_DIRTY; wrn++;
      end
      if (WB_REQ && !prev_req && wbn < 8) begin wb_adr[wbn] = int'(ADR); wbn++; end
      prev_req = WB_REQ;
      if (SWEEP_DONE) begin
        dn++; done_busy = SWEEP_BUSY; done_err = SWEEP_ERR; done_adr = int'(ADR);
        break;
      end
      if (c == inj_c) begin START = 1'b1; FUNC = inj_f; end
    end
  endtask

  task automatic test_reset;
    RESET = 1'b1; START = 1'b0; FUNC = 2'd0; stray = 1'b0; ack_dly = 3; err_adr = -1;
    v_mem = '0; d_mem = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({SWEEP_BUSY, SWEEP_DONE, SWEEP_ERR, DIR_RD, DIR_WR, WR_VALID, WR_DIRTY, WB_REQ} !== 8'd0) begin
      $display("FAIL reset_outputs got=%b exp=00000000", {SWEEP_BUSY, SWEEP_DONE, SWEEP_ERR, DIR_RD, DIR_WR, WR_VALID, WR_DIRTY, WB_REQ}); failures++;
    end
    checks++;
    if (ADR !== 9'd0) begin $display("FAIL reset_adr got=%0d exp=0", ADR); failures++; end
    @(negedge clk); RESET = 1'b0;
  endtask

  task automatic test_empty_invalidate;
    v_mem = '0; d_mem = '1; stray = 1'b1;
    run_sweep(2'd2, -1, 2'd0);
    stray = 1'b0;
    checks++; if (first_busy !== 1'b1 || first_rd !== 1'b1) begin $display("FAIL start_latency busy=%b rd=%b exp=1/1", first_busy, first_rd); failures++; end
    checks++; if (first_adr !== 0) begin $display("FAIL start_adr got=%0d exp=0", first_adr); failures++; end
    checks++; if (busy !== 1024) begin $display("FAIL empty_busy got=%0d exp=1024", busy); failures++; end
    checks++; if (dn !== 1) begin $display("FAIL empty_done got=%0d exp=1", dn); failures++; end
    checks++; if (wrn !== 0 || wbn !== 0) begin $display("FAIL empty_actions wr=%0d wb=%0d exp=0/0", wrn, wbn); failures++; end
    checks++; if (done_busy !== 1'b0) begin $display("FAIL empty_done_busy got=%b exp=0", done_busy); failures++; end
    checks++; if (done_adr !== 0) begin $display("FAIL empty_final_adr got=%0d exp=0", done_adr); failures++; end
    checks++; if (done_err !== 1'b0) begin $display("FAIL stray_ack_err got=%b exp=0", done_err); failures++; end
    @(negedge clk);
    checks++; if (SWEEP_DONE !== 1'b0) begin $display("FAIL done_width got=%b exp=0", SWEEP_DONE); failures++; end
  endtask

  task automatic test_validate;
    for (int i = 0; i < 512; i++) begin v_mem[i] = i[0]; d_mem[i] = i[1]; end
    run_sweep(2'd0, -1, 2'd0);
    checks++; if (busy !== 1536) begin $display("FAIL validate_busy got=%0d exp=1536", busy); failures++; end
    checks++; if (wrn !== 512) begin $display("FAIL validate_writes got=%0d exp=512", wrn); failures++; end
    bad = 0;
    for (int i = 0; i < 512 && i < wrn; i++) if (wr_adr[i] != i || wr_v[i] !== 1'b1 || wr_d[i] !== 1'b0) bad++;
    checks++; if (bad !== 0) begin $display("FAIL validate_order bad_entries=%0d exp=0", bad); failures++; end
    checks++; if (wbn !== 0 || excl !== 0) begin $display("FAIL validate_wb_excl wb=%0d excl=%0d exp=0/0", wbn, excl); failures++; end
  endtask

  task automatic test_unload;
    v_mem = '0; d_mem = '0;
    v_mem[5] = 1'b1; d_mem[5] = 1'b1; v_mem[300] = 1'b1; d_mem[300] = 1'b1;
    v_mem[6] = 1'b1; d_mem[7] = 1'b1;
    ack_dly = 3;
    run_sweep(2'd1, -1, 2'd0);
    checks++; if (busy !== 1034) begin $display("FAIL unload_busy got=%0d exp=1034", busy); failures++; end
    checks++; if (wbn !== 2 || wb_adr[0] !== 5 || wb_adr[1] !== 300) begin $display("FAIL unload_wb n=%0d a0=%0d a1=%0d exp=2/5/300", wbn, wb_adr[0], wb_adr[1]); failures++; end
    checks++;
    if (wrn !== 2 || wr_adr[0] !== 5 || wr_adr[1] !== 300 || {wr_v[0], wr_d[0], wr_v[1], wr_d[1]} !== 4'b1010) begin
      $display("FAIL unload_writes n=%0d a0=%0d a1=%0d vd=%b exp=2/5/300/1010", wrn, wr_adr[0], wr_adr[1], {wr_v[0], wr_d[0], wr_v[1], wr_d[1]}); failures++;
    end
    checks++; if (done_err !== 1'b0 || excl !== 0) begin $display("FAIL unload_err_excl err=%b excl=%0d exp=0/0", done_err, excl); failures++; end
  endtask

  task automatic test_unload_invalidate;
    v_mem = '0; d_mem = '0;
    v_mem[7] = 1'b1; v_mem[8] = 1'b1; d_mem[8] = 1'b1; d_mem[9] = 1'b1;
    ack_dly = 0; err_adr = 8;
    run_sweep(2'd3, -1, 2'd0);
    err_adr = -1;
    checks++; if (busy !== 1027) begin $display("FAIL ui_busy got=%0d exp=1027", busy); failures++; end
    checks++; if (wbn !== 1 || wb_adr[0] !== 8) begin $display("FAIL ui_wb n=%0d a0=%0d exp=1/8", wbn, wb_adr[0]); failures++; end
    checks++;
    if (wrn !== 2 || wr_adr[0] !== 7 || wr_adr[1] !== 8 || {wr_v[0], wr_d[0], wr_v[1], wr_d[1]} !== 4'b0000) begin
      $display("FAIL ui_writes n=%0d a0=%0d a1=%0d vd=%b exp=2/7/8/0000", wrn, wr_adr[0], wr_adr[1], {wr_v[0], wr_d[0], wr_v[1], wr_d[1]}); failures++;
    end
    checks++; if (done_err !== 1'b1) begin $display("FAIL ui_err_at_done got=%b exp=1", done_err); failures++; end
    repeat (5) @(negedge clk);
    checks++; if (SWEEP_ERR !== 1'b1) begin $display("FAIL ui_err_sticky got=%b exp=1", SWEEP_ERR); failures++; end
  endtask

  task automatic test_start_ignored;
    v_mem = '0; d_mem = '0;
    v_mem[10] = 1'b1; v_mem[20] = 1'b1;
    run_sweep(2'd2, 50, 2'd0);
    checks++; if (first_err !== 1'b0) begin $display("FAIL start_clears_err got=%b exp=0", first_err); failures++; end
    checks++; if (busy !== 1026) begin $display("FAIL ignored_busy got=%0d exp=1026", busy); failures++; end
    checks++;
    if (wrn !== 2 || wr_adr[0] !== 10 || wr_adr[1] !== 20 || {wr_v[0], wr_v[1]} !== 2'b00) begin
      $display("FAIL ignored_writes n=%0d a0=%0d a1=%0d v=%b exp=2/10/20/00", wrn, wr_adr[0], wr_adr[1], {wr_v[0], wr_v[1]}); failures++;
    end
  endtask

  task automatic test_back_to_back;
    v_mem = '0; d_mem = '0;
    run_sweep(2'd2, -1, 2'd0);
    START = 1'b1; FUNC = 2'd2;
    @(negedge clk);
    START = 1'b0;
    checks++; if (SWEEP_BUSY !== 1'b1 || ADR !== 9'd0) begin $display("FAIL restart busy=%b adr=%0d exp=1/0", SWEEP_BUSY, ADR); failures++; end
    for (int c = 0; c < 1100 && !SWEEP_DONE; c++) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    v_mem = '0; d_mem = '0;
    v_mem[100] = 1'b1; d_mem[100] = 1'b1;
    ack_dly = 100000;
    @(negedge clk); START = 1'b1; FUNC = 2'd1;
    @(negedge clk); START = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (WB_REQ && ADR == 9'd100) begin found = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (found !== 1'b1) begin $display("FAIL mid_reach_wb got=%b exp=1", found); failures++; end
    RESET = 1'b1;
    @(negedge clk);
    checks++;
    if ({SWEEP_BUSY, SWEEP_DONE, SWEEP_ERR, DIR_RD, DIR_WR, WR_VALID, WR_DIRTY, WB_REQ} !== 8'd0 || ADR !== 9'd0) begin
      $display("FAIL mid_reset_outputs got=%b adr=%0d exp=00000000/0", {SWEEP_BUSY, SWEEP_DONE, SWEEP_ERR, DIR_RD, DIR_WR, WR_VALID, WR_DIRTY, WB_REQ}, ADR); failures++;
    end
    @(negedge clk);
    checks++; if (SWEEP_DONE !== 1'b0) begin $display("FAIL mid_reset_no_done got=%b exp=0", SWEEP_DONE); failures++; end
    RESET = 1'b0; ack_dly = 3; v_mem = '0;
    run_sweep(2'd2, -1, 2'd0);
    checks++; if (first_adr !== 0 || busy !== 1024 || dn !== 1) begin $display("FAIL mid_resweep adr=%0d busy=%0d done=%0d exp=0/1024/1", first_adr, busy, dn); failures++; end
  endtask

  initial begin
    test_reset;
    test_empty_invalidate;
    test_validate;
    test_unload;
    test_unload_invalidate;
    test_start_ignored;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/csh_sweep.md
# csh_sweep

Cache sweep sequencer feeding the APR sweep logic. A single sweep command walks every cache directory entry in order, performs the requested unload/invalidate/validate action on each one, and holds `SWEEP_BUSY` for the whole walk. APR derives its sweep-done interrupt event from `SWEEP_BUSY` falling.

## Interface
Parameters:
- `LINE_BITS`, 7: cache line index width (128 lines).
- `WAY_BITS`, 2: way index width (4 ways). The directory address `ADR` is `{line, way}`, `LINE_BITS+WAY_BITS` wide (9 bits by default).

Ports:
- `clk`, in, 1: EBOX clock. All state changes on the rising edge.
- `RESET`, in, 1: synchronous, active-high master reset.
- `START`, in, 1: one-cycle sweep command pulse from the EBUS function decode.
- `FUNC`, in, 2: sweep function, sampled with `START`.
  - 0: VALIDATE
  - 1: UNLOAD
  - 2: INVALIDATE
  - 3: UNLOAD_INVALIDATE
- `SWEEP_BUSY`, out, 1: sweep in progress.
- `SWEEP_DONE`, out, 1: one-cycle pulse on normal completion.
- `SWEEP_ERR`, out, 1: sticky; set when any writeback errored.
- `DIR_RD`, out, 1: directory read strobe.
- `ADR`, out, 9: current directory entry.
- `DIR_VALID`, in, 1: valid bit of the entry, returned the cycle after `DIR_RD`.
- `DIR_DIRTY`, in, 1: dirty bit of the entry, returned the cycle after `DIR_RD`.
- `DIR_WR`, out, 1: directory write strobe.
- `WR_VALID`, out, 1: valid value written on `DIR_WR`.
- `WR_DIRTY`, out, 1: dirty value written on `DIR_WR`.
- `WB_REQ`, out, 1: writeback request for `ADR` to the MBOX.
- `WB_ACK`, in, 1: writeback complete.
- `WB_ERR`, in, 1: writeback failed (NXM or parity); meaningful only with `WB_ACK`.

## Operation
- States:
  - IDLE
  - READ
  - DECIDE
  - WB
  - WRITE
- IDLE:
  - `START`=1 latches `FUNC`, clears `SWEEP_ERR` and `ADR`, and moves to READ.
  - `START` in any other state is ignored; the latched function does not change.
- READ: `DIR_RD`=1 for one cycle, then DECIDE.
- DECIDE: samples `DIR_VALID`/`DIR_DIRTY` as v/d and selects the action per function:
  - VALIDATE: go to WRITE with `WR_VALID`=1, `WR_DIRTY`=0, unconditionally. No writeback.
  - INVALIDATE: if v, go to WRITE with 0/0; otherwise advance. No writeback.
  - UNLOAD: if v&d, go to WB, then WRITE with 1/0; otherwise advance.
  - UNLOAD_INVALIDATE: if v&d, go to WB, then WRITE with 0/0; else if v, go to WRITE with 0/0; otherwise advance.
- WB:
  - `WB_REQ` is held at 1 until `WB_ACK`=1; an ack in the first WB cycle counts.
  - `WB_ERR`&`WB_ACK` sets `SWEEP_ERR`.
  - The sweep continues after an error, and the entry is still written per its function.
- WRITE: `DIR_WR`=1 for one cycle with `WR_VALID`/`WR_DIRTY` held stable, then advance.
- Advance:
  - `ADR`<`ADR_max` (511 by default): `ADR`+1, then READ.
  - `ADR`=`ADR_max`: go to IDLE and pulse `SWEEP_DONE`. `ADR` wraps to 0.
- Walk order: way varies fastest, then line (entries 0, 1, 2, … map to line0/way0, line0/way1, …).
- `SWEEP_BUSY`=1 in every non-IDLE state.

## Timing
- Reset values:
  - All outputs 0, `ADR`=0, state IDLE.
  - `SWEEP_ERR` is cleared by `RESET`.
  - `RESET` mid-sweep aborts: all outputs go to 0 on the next edge, with no `SWEEP_DONE` pulse.
  - `RESET` has priority over `START` in the same cycle.
- Start latency: `START` at edge n gives `SWEEP_BUSY`=1 and `DIR_RD`=1 after edge n+1.
- Cycles per entry:
  - No action: 2 (READ, DECIDE).
  - Write only: 3.
  - Writeback: 3 + WB cycles, where WB cycles ≥ 1.
- Completion:
  - `SWEEP_DONE` is high for exactly the first IDLE cycle after the last entry.
  - `SWEEP_BUSY` falls in that same cycle.
- Handshake rules:
  - `ADR` is stable from READ through the end of WRITE for that entry.
  - `DIR_RD`, `DIR_WR` and `WB_REQ` are mutually exclusive.
  - `WB_ACK` outside WB is ignored.
- Restart: `START` in the `SWEEP_DONE` cycle begins a new sweep; `SWEEP_BUSY` returns to 1 on the next edge.

## Test plan
- Empty cache (all v=0), INVALIDATE:
  - `SWEEP_BUSY` is high for exactly 1024 cycles.
  - No `DIR_WR`, no `WB_REQ`.
  - `SWEEP_DONE` pulses once, in the cycle `SWEEP_BUSY` falls; final `ADR`=0.
- VALIDATE on any contents: 512 `DIR_WR` pulses, each with 1/0, at `ADR` 0..511 in order; 1536 busy cycles.
- UNLOAD with only entries 5 and 300 valid&dirty, `WB_ACK` returned 3 cycles after `WB_REQ` rises:
  - Exactly 2 writebacks, at `ADR`=5 and `ADR`=300.
  - Each is followed by a `DIR_WR` with 1/0.
  - Total busy cycles = 1024 + 2×(1+4).
- UNLOAD_INVALIDATE with entry 7 valid&clean and entry 8 valid&dirty, with `WB_ERR` on the entry-8 ack:
  - Entry 7 is written 0/0 with no writeback.
  - Entry 8 gets a writeback, then a 0/0 write.
  - `SWEEP_ERR`=1 at done and stays 1 until the next `START`.
- `RESET` asserted at `ADR`=100 during WB:
  - The next cycle has all outputs 0 and no `SWEEP_DONE`.
  - A later `START` sweeps again from `ADR`=0.
- `START` pulsed mid-sweep with a different `FUNC`: ignored. The sweep completes with the original function and the original cycle count.
